// File: rtl/omsp_ps2_ctrl.sv
// openMSP430 peripheral: PS/2 keyboard controller with an RX FIFO and a host-to-keyboard
// command sequencer. Define PS2_CTRL_RETRY_EN to resend a byte answered with 0xFE.
module omsp_ps2_ctrl #(
  parameter logic [14:0] BASE_ADDR       = 15'h00a8,
  parameter int unsigned DEC_WD          = 3,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3,
  parameter logic [19:0] TIMEOUT_CYC     = 20'd200000,
  parameter int unsigned MAX_RETRY       = 2
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic        irq_ps2,
  input  logic [7:0]  kbd_rx_code,
  input  logic        kbd_rx_ready,
  output logic        kbd_rx_read,
  output logic [7:0]  kbd_tx_data,
  output logic        kbd_tx_write,
  input  logic        kbd_tx_ack,
  input  logic        kbd_tx_noack
);

  localparam int unsigned IW    = DEC_WD - 1;
  localparam int unsigned AW    = FIFO_DEPTH_LOG2;
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;

  typedef enum logic [2:0] {StIdle, StSend, StWaitTx, StWaitAck, StDone, StFail} tx_state_e;

  // Bus decode
  logic          reg_sel, reg_wr, reg_rd;
  logic [IW-1:0] reg_idx;
  logic          status_wr, rxdata_rd, txcmd_wr, ctrl_wr;

  assign reg_sel   = per_en & (per_addr[13:IW] == BASE_ADDR[14:DEC_WD]);
  assign reg_idx   = per_addr[IW-1:0];
  assign reg_wr    = reg_sel & (|per_we);
  assign reg_rd    = reg_sel & ~(|per_we);
  assign status_wr = reg_wr & per_we[0] & (reg_idx == IW'(0));
  assign rxdata_rd = reg_rd & (reg_idx == IW'(1));
  assign txcmd_wr  = reg_wr & per_we[0] & (reg_idx == IW'(2));
  assign ctrl_wr   = reg_wr & per_we[0] & (reg_idx == IW'(3));

  logic [1:0] ctrl_q;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst)      ctrl_q <= 2'b00;
    else if (ctrl_wr) ctrl_q <= per_din[1:0];
  end

  // RX handshake: one consume pulse per held byte; the byte is taken while the pulse is high.
  logic rx_read_q;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) rx_read_q <= 1'b0;
    else         rx_read_q <= kbd_rx_ready & ~rx_read_q;
  end

  assign kbd_rx_read = rx_read_q;

  tx_state_e state_q, state_d;
  logic      is_ack, is_resend, fsm_eat, push, push_ok, pop;

  assign is_ack    = (kbd_rx_code == 8'hFA);
  assign is_resend = (kbd_rx_code == 8'hFE);
  assign fsm_eat   = rx_read_q & (state_q == StWaitAck) & (is_ack | is_resend);
  assign push      = rx_read_q & ~fsm_eat;

  // RX FIFO
  logic [7:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          rx_nempty, rx_full, rx_ovf_q;
  logic [7:0]    rx_head;

  assign rx_nempty = (count_q != '0);
  assign rx_full   = (count_q == (AW+1)'(DEPTH));
  assign push_ok   = push & ~rx_full;
  assign pop       = rxdata_rd & rx_nempty;
  assign rx_head   = rx_nempty ? fifo_mem[rd_ptr_q] : 8'h00;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rx_ovf_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (!push_ok && pop) count_q <= count_q - (AW+1)'(1);
      if (push && rx_full)               rx_ovf_q <= 1'b1;
      else if (status_wr && per_din[2])  rx_ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge mclk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= kbd_rx_code;
  end

  // TX sequencer
  logic [7:0]  cmd_q, cmd_d, arg_q, arg_d;
  logic        two_byte_q, two_byte_d, on_arg_q, on_arg_d;
  logic [19:0] timer_q, timer_d;
  logic        tx_busy_q, tx_busy_d, tx_done_q, tx_done_d, tx_err_q, tx_err_d;
`ifdef PS2_CTRL_RETRY_EN
  logic [7:0]  retry_q, retry_d;
`else
  logic        unused_max_retry;
  assign unused_max_retry = ^MAX_RETRY;
`endif

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    two_byte_d = two_byte_q;
    on_arg_d   = on_arg_q;
    timer_d    = timer_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = tx_done_q;
    tx_err_d   = tx_err_q;
`ifdef PS2_CTRL_RETRY_EN
    retry_d    = retry_q;
`endif
    if (status_wr && per_din[4]) tx_done_d = 1'b0;
    if (status_wr && per_din[5]) tx_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (txcmd_wr) begin
          cmd_d      = per_din[7:0];
          arg_d      = per_din[15:8];
          two_byte_d = per_we[1];
          on_arg_d   = 1'b0;
          tx_busy_d  = 1'b1;
          tx_done_d  = 1'b0;
          tx_err_d   = 1'b0;
`ifdef PS2_CTRL_RETRY_EN
          retry_d    = '0;
`endif
          state_d    = StSend;
        end
      end
      StSend: state_d = StWaitTx;
      StWaitTx: begin
        if (kbd_tx_ack) begin
          timer_d = TIMEOUT_CYC;
          state_d = StWaitAck;
        end else if (kbd_tx_noack) begin
          state_d = StFail;
        end
      end
      StWaitAck: begin
        // A response byte wins over a timeout expiring in the same cycle.
        if (fsm_eat && is_ack) begin
          if (two_byte_q && !on_arg_q) begin
            on_arg_d = 1'b1;
`ifdef PS2_CTRL_RETRY_EN
            retry_d  = '0;
`endif
            state_d  = StSend;
          end else begin
            state_d  = StDone;
          end
        end else if (fsm_eat) begin
`ifdef PS2_CTRL_RETRY_EN
          if (32'(retry_q) >= MAX_RETRY) begin
            state_d = StFail;
          end else begin
            retry_d = retry_q + 8'd1;
            state_d = StSend;
          end
`else
          state_d = StFail;
`endif
        end else if (timer_q <= 20'd1) begin
          state_d = StFail;
        end else begin
          timer_d = timer_q - 20'd1;
        end
      end
      StDone: begin
        tx_done_d = 1'b1;
        tx_busy_d = 1'b0;
        state_d   = StIdle;
      end
      StFail: begin
        tx_err_d  = 1'b1;
        tx_busy_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q    <= StIdle;
      cmd_q      <= 8'h00;
      arg_q      <= 8'h00;
      two_byte_q <= 1'b0;
      on_arg_q   <= 1'b0;
      timer_q    <= '0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
`ifdef PS2_CTRL_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      two_byte_q <= two_byte_d;
      on_arg_q   <= on_arg_d;
      timer_q    <= timer_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
`ifdef PS2_CTRL_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign kbd_tx_write = (state_q == StSend);
  assign kbd_tx_data  = on_arg_q ? arg_q : cmd_q;

  assign irq_ps2 = (rx_nempty & ctrl_q[0]) | ((tx_done_q | tx_err_q) & ctrl_q[1]);

  always_comb begin
    per_dout = 16'h0000;
    if (reg_rd) begin
      case (reg_idx)
        IW'(0):  per_dout = {10'h000, tx_err_q, tx_done_q, tx_busy_q, rx_ovf_q, rx_full, rx_nempty};
        IW'(1):  per_dout = {8'h00, rx_head};
        IW'(3):  per_dout = {14'h0000, ctrl_q};
        default: per_dout = 16'h0000;
      endcase
    end
  end

endmodule
